// File: rtl/kbd_event_ctrl_if.sv
// rtl/kbd_event_ctrl_if.sv - key input and event FIFO bus for kbd_event_ctrl
interface kbd_event_ctrl_if;
  logic [7:0] key_ascii;
  logic       key_ctrl;
  logic       rep_en;
  logic       ev_ack;
  logic       clr_ovf;
  logic       ev_valid;
  logic [8:0] ev_data;
  logic [4:0] ev_count;
  logic       overflow;

  modport master (
    output key_ascii, key_ctrl, rep_en, ev_ack, clr_ovf,
    input  ev_valid, ev_data, ev_count, overflow
  );

  modport slave (
    input  key_ascii, key_ctrl, rep_en, ev_ack, clr_ovf,
    output ev_valid, ev_data, ev_count, overflow
  );
endinterface

// File: rtl/kbd_event_ctrl.sv
// rtl/kbd_event_ctrl.sv - typematic key event generator feeding a show-ahead event FIFO
module kbd_event_ctrl #(
  parameter int DELAY_CYC = 25000000,
  parameter int RATE_CYC  = 2500000,
  parameter int DEPTH     = 8
) (
  input logic             clk,
  input logic             rst,
  kbd_event_ctrl_if.slave bus
);

  localparam int MAX_CYC = (DELAY_CYC > RATE_CYC) ? DELAY_CYC : RATE_CYC;
  localparam int CW      = $clog2(MAX_CYC);
  localparam int AW      = $clog2(DEPTH);

  localparam logic [CW-1:0] DLY_LAST  = CW'(DELAY_CYC - 1);
  localparam logic [CW-1:0] RATE_LAST = CW'(RATE_CYC - 1);
  localparam logic [4:0]    FULL_CNT  = 5'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      held_q, held_d;

  logic [8:0]      mem_q [DEPTH];
  logic [8:0]      mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [4:0]      count_q, count_d;
  logic            overflow_q, overflow_d;

  logic            push;
  logic [8:0]      push_data;
  logic            pop;
  logic            full;
  logic            wr_en;

  // Typematic generator: decides on at most one push per cycle.
  // The held key is compared on ascii only, so a ctrl change never restarts typematic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    held_d    = held_q;
    push      = 1'b0;
    push_data = {bus.key_ctrl, bus.key_ascii};
    case (state_q)
      ST_IDLE: begin
        if (bus.key_ascii != 8'h00) begin
          push    = 1'b1;
          held_d  = bus.key_ascii;
          cnt_d   = '0;
          state_d = ST_DELAY;
        end
      end
      ST_DELAY, ST_REPEAT: begin
        if (bus.key_ascii == 8'h00) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (bus.key_ascii != held_q) begin
          push    = 1'b1;
          held_d  = bus.key_ascii;
          cnt_d   = '0;
          state_d = ST_DELAY;
        end else if (!bus.rep_en) begin
          cnt_d = '0;
        end else if (cnt_q == ((state_q == ST_DELAY) ? DLY_LAST : RATE_LAST)) begin
          push      = 1'b1;
          push_data = {bus.key_ctrl, held_q};
          cnt_d     = '0;
          state_d   = ST_REPEAT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FIFO next state: a pop frees the slot that a same-cycle push needs when full.
  always_comb begin
    pop        = bus.ev_ack && (count_q != 5'd0);
    full       = (count_q == FULL_CNT);
    wr_en      = push && (!full || pop);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
    if (push && !wr_en) begin
      overflow_d = 1'b1;
    end else if (bus.clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  // State registers; reset drops stored events and any pending repeat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      held_q     <= 8'h00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= 5'd0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 9'h000;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      held_q     <= held_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
    end
  end

  assign bus.ev_valid = (count_q != 5'd0);
  assign bus.ev_data  = (count_q != 5'd0) ? mem_q[rd_ptr_q] : 9'h000;
  assign bus.ev_count = count_q;
  assign bus.overflow = overflow_q;

endmodule
